// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 lane scheduler and its arbiter.
package md5_pkg;

  localparam int MD5_TEXT_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ABORT = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

  // One slice of the candidate space handed to a lane.
  typedef struct packed {
    logic [63:0] index;
    logic [31:0] len;
  } lane_slice_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting lane at or after ptr.
module rr_arbiter
  import md5_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int PTR_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [WIDTH-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [WIDTH-1:0] hit_at;
  logic [PTR_W-1:0] lane_at [WIDTH];

  // Offset gi from the pointer maps to lane (ptr + gi) mod WIDTH.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_off
      logic [PTR_W:0] sum;
      logic [PTR_W:0] wrapped;
      assign sum         = {1'b0, ptr} + (PTR_W+1)'(gi);
      assign wrapped     = sum - (PTR_W+1)'(WIDTH);
      assign lane_at[gi] = (sum >= (PTR_W+1)'(WIDTH)) ? wrapped[PTR_W-1:0] : sum[PTR_W-1:0];
      assign hit_at[gi]  = req[lane_at[gi]];
    end
  endgenerate

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (en && hit_at[i]) begin
        grant_valid = 1'b1;
        grant_idx   = lane_at[i];
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/md5_lane_scheduler.sv
// Splits one brute-force job into slices for NUM_LANES MD5 lanes, captures the
// first match, aborts the rest and reports a single found/done result.
module md5_lane_scheduler
  import md5_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int SLICE_LEN = 65536,
  parameter int INDEX_W   = 64
) (
  input  logic                              clk,
  input  logic                              reset2,
  input  logic                              start,
  input  logic                              stop,
  input  logic [INDEX_W-1:0]                start_index,
  input  logic [INDEX_W-1:0]                end_index,
  input  logic [NUM_LANES-1:0]              lane_req,
  input  logic [NUM_LANES-1:0]              lane_done,
  input  logic [NUM_LANES-1:0]              lane_match,
  input  logic [NUM_LANES*MD5_TEXT_W-1:0]   lane_text,
  output logic [NUM_LANES-1:0]              lane_grant,
  output logic [INDEX_W-1:0]                grant_index,
  output logic [$clog2(SLICE_LEN+1)-1:0]    grant_len,
  output logic                              abort,
  output logic                              busy,
  output logic                              done,
  output logic                              found,
  output logic [$clog2(NUM_LANES)-1:0]      found_lane,
  output logic [MD5_TEXT_W-1:0]             found_text,
  output logic [31:0]                       slices_issued
);

  localparam int LEN_W = $clog2(SLICE_LEN + 1);
  localparam int PTR_W = $clog2(NUM_LANES);
  localparam logic [INDEX_W-1:0] SLICE_IDX = INDEX_W'(SLICE_LEN);

  sched_state_t         state_reg, state_next;
  logic [INDEX_W-1:0]   next_index_reg, end_reg, remaining, next_index_adv;
  logic [PTR_W-1:0]     rr_ptr_reg, arb_idx, match_idx;
  logic [NUM_LANES-1:0] busy_mask_reg, busy_mask_next;
  logic [NUM_LANES-1:0] live_done, live_match, eligible, arb_grant;
  logic                 arb_valid, arb_en, any_match, start_ok, have_work;
  logic                 busy_c, done_c, abort_c;
  lane_slice_t          slice_c;

  // Pulses from lanes that hold no slice are stale and ignored.
  assign live_done  = lane_done & busy_mask_reg;
  assign live_match = lane_match & busy_mask_reg;
  assign any_match  = |live_match;
  assign eligible   = lane_req & ~busy_mask_reg;
  assign have_work  = next_index_reg < end_reg;
  assign start_ok   = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign arb_en     = (state_reg == ST_RUN) && have_work && !any_match && !stop;

  rr_arbiter #(.WIDTH(NUM_LANES)) u_arb (
    .req        (eligible),
    .ptr        (rr_ptr_reg),
    .en         (arb_en),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  // remaining is only meaningful when have_work holds, which arb_en requires.
  assign remaining = end_reg - next_index_reg;

  always_comb begin
    slice_c.index = 64'(next_index_reg);
    slice_c.len   = (remaining < SLICE_IDX) ? 32'(remaining) : 32'(SLICE_LEN);
  end

  assign next_index_adv = next_index_reg + INDEX_W'(slice_c.len);
  assign busy_mask_next = (busy_mask_reg & ~live_done) | arb_grant;

  always_comb begin
    match_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (live_match[i]) match_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset2) begin
    if (reset2) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = (end_index <= start_index) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        if (any_match || stop)                           state_next = ST_ABORT;
        else if (arb_valid && next_index_adv == end_reg) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (any_match || stop)          state_next = ST_ABORT;
        else if (busy_mask_next == '0)  state_next = ST_DONE;
      end
      ST_ABORT: begin
        if (busy_mask_next == '0) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_c  = (state_next == ST_RUN) || (state_next == ST_DRAIN) || (state_next == ST_ABORT);
    abort_c = (state_next == ST_ABORT);
    done_c  = (state_next == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset2) begin
    if (reset2) begin
      lane_grant     <= '0;
      grant_index    <= '0;
      grant_len      <= '0;
      abort          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      found          <= 1'b0;
      found_lane     <= '0;
      found_text     <= '0;
      slices_issued  <= '0;
      next_index_reg <= '0;
      end_reg        <= '0;
      rr_ptr_reg     <= '0;
      busy_mask_reg  <= '0;
    end else begin
      busy          <= busy_c;
      abort         <= abort_c;
      done          <= done_c;
      lane_grant    <= arb_grant;
      busy_mask_reg <= busy_mask_next;
      if (start_ok) begin
        next_index_reg <= start_index;
        end_reg        <= end_index;
        found          <= 1'b0;
        found_lane     <= '0;
        found_text     <= '0;
        slices_issued  <= '0;
      end
      if (arb_valid) begin
        grant_index    <= INDEX_W'(slice_c.index);
        grant_len      <= LEN_W'(slice_c.len);
        next_index_reg <= next_index_adv;
        rr_ptr_reg     <= (arb_idx == PTR_W'(NUM_LANES - 1)) ? '0 : arb_idx + 1'b1;
        if (slices_issued != '1) slices_issued <= slices_issued + 32'd1;
      end
      if ((state_reg == ST_RUN || state_reg == ST_DRAIN) && any_match) begin
        found      <= 1'b1;
        found_lane <= match_idx;
        found_text <= lane_text[match_idx*MD5_TEXT_W +: MD5_TEXT_W];
      end
    end
  end

endmodule
